// File: rtl/ysyx_23060124_lsu_axi.sv
// ysyx_23060124_lsu_axi: single-beat AXI4 load/store unit between EXU and WBU.
// Define LSU_MISALIGN_CHK_EN to fault misaligned accesses without issuing bus traffic.
module ysyx_23060124_lsu_axi #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int AXI_ID = 0
) (
    input  logic                  clock,
    input  logic                  i_rst_n,
    input  logic                  i_pre_valid,
    output logic                  o_pre_ready,
    input  logic                  i_load,
    input  logic                  i_store,
    input  logic [2:0]            i_opt,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic                  o_post_valid,
    input  logic                  i_post_ready,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_err,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [3:0]            M_AXI_ARID,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    input  logic [3:0]            M_AXI_RID,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [3:0]            M_AXI_AWID,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic [3:0]            M_AXI_BID
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W = $clog2(STRB_W);
    typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rshift, mask, rext;
    logic [2:0] opt;
    logic [OFF_W-1:0] off;
    logic [STRB_W-1:0] smask;
    logic [6:0] nbits;
    logic aw_done, w_done, aw_hs, w_hs, accept, bad, mis, req_err, unused_ok;
`ifdef LSU_MISALIGN_CHK_EN
    assign mis = (i_opt[1:0] == 2'd1 && i_addr[0]) || (i_opt[1:0] == 2'd2 && i_addr[1:0] != 2'd0) ||
                 (i_opt[1:0] == 2'd3 && i_addr[2:0] != 3'd0);
`else
    assign mis = 1'b0;
`endif
    // Doubleword and lwu only exist on a 64-bit bus
    assign bad = (DATA_W == 32) && (i_opt == 3'b011 || i_opt == 3'b110);
    assign req_err = (i_load || i_store) && (bad || mis);
    assign accept = i_pre_valid && o_pre_ready;
    assign o_pre_ready = i_rst_n && state == IDLE;
    assign o_post_valid = state == RESP;
    assign M_AXI_ARVALID = state == AR;
    assign M_AXI_RREADY = state == R;
    assign M_AXI_AWVALID = state == AWW && !aw_done;
    assign M_AXI_WVALID = state == AWW && !w_done;
    assign M_AXI_BREADY = state == B;
    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs = M_AXI_WVALID && M_AXI_WREADY;
    assign M_AXI_ARADDR = addr;
    assign M_AXI_AWADDR = addr;
    assign M_AXI_ARID = 4'(AXI_ID);
    assign M_AXI_AWID = 4'(AXI_ID);
    assign M_AXI_ARLEN = 8'd0;
    assign M_AXI_AWLEN = 8'd0;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_ARSIZE = {1'b0, opt[1:0]};
    assign M_AXI_AWSIZE = {1'b0, opt[1:0]};
    assign off = addr[OFF_W-1:0];
    assign smask = ~({STRB_W{1'b1}} << (4'd1 << opt[1:0]));
    assign M_AXI_WDATA = wdata << {off, 3'b000};
    assign M_AXI_WSTRB = smask << off;
    assign M_AXI_WLAST = 1'b1;
    // Lanes past the top of the bus shift out as zeros, so oversized accesses truncate
    assign rshift = M_AXI_RDATA >> {off, 3'b000};
    assign nbits = 7'd8 << opt[1:0];
    assign mask = ~({DATA_W{1'b1}} << nbits);
    assign rext = (rshift & mask) | ({DATA_W{!opt[2] && |(rshift & mask & ~(mask >> 1))}} & ~mask);
    assign unused_ok = ^{M_AXI_RID, M_AXI_BID};
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (req_err || !(i_load || i_store)) ? RESP : i_load ? AR : AWW;
            AR: if (M_AXI_ARREADY) state_nx = R;
            R: if (M_AXI_RVALID && M_AXI_RLAST) state_nx = RESP;
            AWW: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = B;
            B: if (M_AXI_BVALID) state_nx = RESP;
            RESP: if (i_post_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {addr, wdata, opt, aw_done, w_done, o_rdata, o_err} <= '0;
        end else begin
            if (accept) begin
                addr <= i_addr;
                wdata <= i_wdata;
                opt <= i_opt;
                aw_done <= 1'b0;
                w_done <= 1'b0;
                o_rdata <= '0;
                o_err <= req_err;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (state == R && M_AXI_RVALID && M_AXI_RLAST) begin
                o_rdata <= rext;
                o_err <= |M_AXI_RRESP;
            end
            if (state == B && M_AXI_BVALID) o_err <= |M_AXI_BRESP;
        end
    end
endmodule

// File: doc/ysyx_23060124_lsu_axi.md
YSYX_23060124_LSU_AXI -- requirements
Module: ysyx_23060124_lsu_axi

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data/bus width; legal values are 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter AXI_ID, default 0, meaning the constant driven on M_AXI_ARID and M_AXI_AWID.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports i_pre_valid (input, 1) and o_pre_ready (output, 1), the request handshake from the EXU.
REQ-007 SHALL have ports i_load (input, 1), i_store (input, 1) and i_opt (input, 3), the access type and funct3 size/sign code.
REQ-008 SHALL have ports i_addr (input, ADDR_W) and i_wdata (input, DATA_W), the byte address and the store data (LSB-aligned).
REQ-009 SHALL have ports o_post_valid (output, 1) and i_post_ready (input, 1), the result handshake to the WBU.
REQ-010 SHALL have ports o_rdata (output, DATA_W) and o_err (output, 1), the extended load result and the access error flag.
REQ-011 SHALL have the full AXI4 master AR, R, AW, W and B channels named M_AXI_*, with widths as in the existing EXU and the data width set by DATA_W.

Function
REQ-012 SHALL implement an FSM with states IDLE, AR, R, AWW, B and RESP.
REQ-013 SHALL drive o_pre_ready=1 only in IDLE, and SHALL latch addr/wdata/opt/type on i_pre_valid&&o_pre_ready.
- On a load the FSM SHALL move to AR.
- On a store the FSM SHALL move to AWW.
- With neither type asserted the FSM SHALL move directly to RESP with o_rdata=0 and o_err=0.
REQ-014 In AR the block SHALL hold ARVALID=1 with a stable ARADDR (the latched address) until ARREADY is seen, then move to R.
REQ-015 The AR and AW fields SHALL be: ARLEN/AWLEN=0, ARBURST/AWBURST=2'b01, and ARSIZE/AWSIZE = log2 of the access bytes taken from i_opt[1:0].
REQ-016 In R the block SHALL drive RREADY=1, and on RVALID&&RLAST it SHALL capture the data and move to RESP.
- The result SHALL be the lane selected by addr[log2(DATA_W/8)-1:0], sign-extended when i_opt[2]=0 and zero-extended otherwise.
REQ-017 In AWW the block SHALL assert AWVALID and WVALID together.
- Each valid SHALL drop independently after its own handshake.
- The FSM SHALL move to B only when both handshakes have completed, in any order, including the same cycle.
REQ-018 The write data fields SHALL be:
- WDATA = wdata shifted left by 8*offset;
- WSTRB = size mask shifted left by offset;
- WLAST = 1.
REQ-019 In B the block SHALL drive BREADY=1, and on BVALID it SHALL move to RESP.
REQ-020 o_err SHALL be set when the captured RRESP or BRESP is nonzero; o_rdata SHALL be 0 for stores.
REQ-021 In RESP, o_post_valid SHALL be 1, with o_rdata and o_err held stable until i_post_ready, after which the FSM SHALL return to IDLE.
REQ-022 Load latency with a zero-wait slave SHALL be: accept at cycle T, ARVALID at T+1, R beat at T+2, o_post_valid at T+3.
REQ-023 Outside their respective states, RREADY and BREADY SHALL be 0, so stray responses are not consumed.
REQ-024 When DATA_W=64, i_opt 3'b011 (ld/sd) and 3'b110 (lwu) SHALL be legal; when DATA_W=32 they SHALL set o_err=1 and bypass the AXI channels.

Reset
REQ-025 On i_rst_n=0 the block SHALL asynchronously enter IDLE and clear all valid/ready outputs, o_rdata, o_err and the latched request, including when reset occurs mid-transaction.
REQ-026 After reset release, o_pre_ready SHALL be 1 in the first cycle.

Configuration
REQ-027 With LSU_MISALIGN_CHK_EN defined, a misaligned access SHALL issue no AXI traffic and SHALL go to RESP with o_err=1 and o_rdata=0.
- Misaligned means: halfword at an odd address, word with addr[1:0]!=0, or doubleword with addr[2:0]!=0.
REQ-028 Without LSU_MISALIGN_CHK_EN, no check SHALL be made: the access SHALL be issued as-is, and lanes beyond the bus SHALL be truncated.

Verification
REQ-029 lw at 0x80000004 (DATA_W=32), zero-wait slave, R=0x12345678 -> o_post_valid at T+3, o_rdata=0x12345678, o_err=0.
REQ-030 lb at 0x80000003, R=0x80FF0000 -> o_rdata=0xFFFFFF80; lbu -> 0x00000080.
REQ-031 sh at 0x80000002, wdata=0xBEEF, WREADY 3 cycles after AWREADY -> WDATA=0xBEEF0000, WSTRB=4'b1100, one B handshake, o_post_valid held until i_post_ready.
REQ-032 lw with RRESP=2'b10 -> o_err=1; i_post_ready held 0 for 4 cycles -> o_post_valid/o_rdata stable, o_pre_ready=0.
REQ-033 With LSU_MISALIGN_CHK_EN, lw at 0x80000001 -> no ARVALID, o_err=1 at T+1; without it -> ARVALID with ARADDR 0x80000001.
REQ-034 i_rst_n pulsed low during state R -> all outputs 0 immediately, IDLE with o_pre_ready=1 after release, a later RVALID not accepted.
